// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM request tracking, one-entry skid buffer and registered output.
// Optional delivered-instruction counter enabled by defining FETCH_COUNT_EN.
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  stall,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  deliver;

    // Reset overrides a concurrent branch so the ROM sees RESET_PC while held in reset.
    always_comb begin
        if (reset) begin
            rom_addr = RESET_PC;
        end else if (branch_valid) begin
            rom_addr = branch_target;
        end else begin
            rom_addr = pc_q;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        deliver      = 1'b0;

        if (branch_valid) begin
            // Any in-flight word and any skid entry belong to the old path.
            inst_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            req_pc_d     = branch_target;
            req_valid_d  = 1'b1;
            pc_d         = branch_target + ADDR_WIDTH'(1);
        end else if (stall) begin
            req_valid_d = 1'b0;
            if (req_valid_q) begin
                skid_data_d  = rom_data;
                skid_pc_d    = req_pc_q;
                skid_valid_d = 1'b1;
            end
        end else begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_WIDTH'(1);
            // Skid holds the older word; req_valid is never set alongside it here.
            if (skid_valid_q) begin
                inst_d       = skid_data_q;
                inst_pc_d    = skid_pc_q;
                inst_valid_d = 1'b1;
                skid_valid_d = 1'b0;
                deliver      = 1'b1;
            end else if (req_valid_q) begin
                inst_d       = rom_data;
                inst_pc_d    = req_pc_q;
                inst_valid_d = 1'b1;
                deliver      = 1'b1;
            end else begin
                inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (deliver) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the simple CPU. Owns the program counter, drives the address of the synchronous instruction ROM (one-cycle registered read), and pairs each returned word with its address. Delivers one instruction per cycle to decode, with stall back-pressure, branch redirect, and a one-entry skid buffer so no ROM word is lost or refetched when a stall arrives.

## Interface
- ADDR_WIDTH, 8, instruction address width; PC wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 0, first address fetched after reset
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rom_addr  out  ADDR_WIDTH  ROM read address, combinational
- rom_data  in  DATA_WIDTH  ROM word for the address presented on the previous edge
- stall  in  1  decode cannot accept; hold inst outputs
- branch_valid  in  1  redirect fetch this cycle
- branch_target  in  ADDR_WIDTH  redirect address
- inst  out  DATA_WIDTH  delivered instruction, registered
- inst_pc  out  ADDR_WIDTH  address of inst, registered
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- fetch_count  out  32  delivered-instruction counter (only with FETCH_COUNT_EN)

## Operation
- State: pc, req_valid, req_pc, skid_valid, skid_data, skid_pc, inst, inst_pc, inst_valid.
- Reset (async, immediate): pc=RESET_PC; req_valid, skid_valid, inst_valid=0; inst, inst_pc, skid_*=0. rom_addr reads RESET_PC while reset is high.
- rom_addr = branch_valid ? branch_target : pc.
- Priority per edge: branch_valid > stall > normal.
- Branch (stall ignored): inst_valid<=0; skid_valid<=0; req_pc<=branch_target; req_valid<=1; pc<=branch_target+1. In-flight rom_data is discarded.
- Stall, no branch: pc, inst, inst_pc, inst_valid hold; req_valid<=0. If req_valid=1: skid_data<=rom_data, skid_pc<=req_pc, skid_valid<=1.
- Normal: issue rom_addr (req_pc<=pc, req_valid<=1, pc<=pc+1). Output load: if skid_valid then inst<=skid_data, inst_pc<=skid_pc, inst_valid<=1, skid_valid<=0; else if req_valid then inst<=rom_data, inst_pc<=req_pc, inst_valid<=1; else inst_valid<=0.
- Skid cannot overflow: nothing is issued during a stall, so at most one word is in flight when a stall starts, and req_valid=0 whenever skid_valid=1 on a normal cycle.
- PC arithmetic: unsigned, ADDR_WIDTH bits, wraps 2^ADDR_WIDTH-1 -> 0, no flag.

## Timing
- Address presented on edge N; word on rom_data in cycle N+1; inst_valid by edge N+2. Fetch latency is 2 cycles.
- After reset release: first inst_valid=1 (inst_pc=RESET_PC) on the 2nd rising edge.
- Steady state: 1 instruction per cycle, no bubbles.
- Stall: zero bubbles after release. The held word stays on the outputs. The skid word is delivered on the first edge after release, and the next sequential word follows on the edge after that.
- Branch: exactly 1 bubble cycle (inst_valid=0), then inst_pc=target.
- Reset asserted mid-stream: all outputs go to reset values without a clock edge, and fetch restarts from RESET_PC.

## Configuration
- FETCH_COUNT_EN defined: port fetch_count exists.
  - Reset value 0, asynchronous with reset.
  - Increments by 1 on every edge where inst is loaded with an instruction (from skid or ROM) and inst_valid<=1.
  - Wraps at 2^32; branches do not clear it.
- FETCH_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Bench ROM model: registered 1-cycle read, mem[i]=0xA5000000|i.
- Reset release, stall=0, no branch: inst_valid rises on 2nd edge with inst_pc=0x00, inst=0xA5000000. Then inst_pc 0x01, 0x02… on consecutive edges, and inst=mem[inst_pc] every cycle.
- stall=1 for 3 cycles while inst_pc=0x05: inst stays 0xA5000005. After release, inst_pc=0x06 then 0x07 on consecutive edges, with no gap and no duplicate.
- branch_valid=1, branch_target=0x40 while inst_pc=0x03: next edge inst_valid=0; following edge inst_pc=0x40, inst=0xA5000040; then 0x41.
- Branch to 0xFE: inst_pc sequence 0xFE, 0xFF, 0x00, 0x01 with no bubble at the wrap.
- branch_valid=1 and stall=1 in the same cycle, target 0x20, skid full: the branch wins. inst_valid=0 next edge, the skid word is never delivered, and inst_pc=0x20 follows.
- With FETCH_COUNT_EN: after 10 deliveries fetch_count=10. Assert reset mid-cycle: fetch_count, inst_valid and inst_pc are 0 before the next clock edge.
